// File: rtl/pipe_result_collector.sv
// Tail-end collector for a valid-only pipeline: results go into a FIFO and leave on a valid/ready port.
// A credit counter limits issue into the pipe head, so every returning result has a free slot.
module pipe_result_collector #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_vld,
  output logic                     issue_rdy,
  input  logic                     res_vld,
  input  logic [width-1:0]         res_data,
  output logic                     out_vld,
  output logic [width-1:0]         out_data,
  input  logic                     out_rdy,
  output logic [$clog2(depth):0]   credits,
  output logic                     overflow
);

  localparam int aw = $clog2(depth);
  localparam logic [aw:0] max_credits = (aw + 1)'(depth);

  logic [width-1:0] mem [depth];
  logic [aw:0]      wr_ptr;
  logic [aw:0]      rd_ptr;
  logic             full;
  logic             empty;
  logic             issue;
  logic             pop;
  logic             push;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[aw] != rd_ptr[aw]) && (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);

  assign issue_rdy = (credits != '0) && !rst;
  assign issue     = issue_vld && issue_rdy;
  assign out_vld   = !empty;
  assign out_data  = mem[rd_ptr[aw-1:0]];
  assign pop       = out_vld && out_rdy;
  assign push      = res_vld && !full;

  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= max_credits;
    end else if (issue && !pop && credits != '0) begin
      credits <= credits - 1'b1;
    end else if (pop && !issue && credits != max_credits) begin
      credits <= credits + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; out_data is only meaningful while out_vld is high.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[aw-1:0]] <= res_data;
  end

  // A result arriving while full is dropped and flagged until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (res_vld && full) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_result_collector.sv
// Bench for pipe_result_collector: the bench plays the upstream pipeline and keeps a queue
// model of FIFO contents, credits and overflow, compared against the DUT on every negedge.
module tb_pipe_result_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_vld;
  logic       issue_rdy;
  logic       res_vld;
  logic [7:0] res_data;
  logic       out_vld;
  logic [7:0] out_data;
  logic       out_rdy;
  logic [2:0] credits;
  logic       overflow;

  pipe_result_collector #(.width(8), .depth(4)) dut (
    .clk(clk), .rst(rst),
    .issue_vld(issue_vld), .issue_rdy(issue_rdy),
    .res_vld(res_vld), .res_data(res_data),
    .out_vld(out_vld), .out_data(out_data), .out_rdy(out_rdy),
    .credits(credits), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Model state: FIFO contents as a queue, free credits, sticky overflow.
  logic [7:0] q[$];
  int         m_cred = 4;
  bit         m_ovf  = 1'b0;

  // Upstream pipeline: slot k is presented at the tail k cycles from now.
  bit         pv[8];
  logic [7:0] pd[8];
  int         lat = 3;
  bit         frc_v = 1'b0;
  logic [7:0] frc_d = 8'h00;
  logic [7:0] next_tag = 8'hA1;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  int n_issued = 0;
  bit chk_en = 1'b0;
  bit inv_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int inflight();
    int n = 0;
    for (int i = 0; i < 8; i++) if (pv[i]) n++;
    return n;
  endfunction

  task automatic drive_res();
    res_vld  = pv[0] | frc_v;
    res_data = frc_v ? frc_d : pd[0];
  endtask

  // Advance one clock; the model consumes the inputs that were stable across the edge.
  task automatic step();
    bit fire, popm, fullm;
    fire  = !rst && issue_vld && (m_cred != 0);
    popm  = !rst && (q.size() != 0) && out_rdy;
    fullm = (q.size() == 4);
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      m_cred = 4;
      m_ovf  = 1'b0;
      for (int i = 0; i < 8; i++) pv[i] = 1'b0;
    end else begin
      if (res_vld && fullm) m_ovf = 1'b1;
      if (popm) begin
        void'(q.pop_front());
        pops++;
      end
      if (res_vld && !fullm) q.push_back(res_data);
      if (fire && !popm) m_cred--;
      else if (popm && !fire && m_cred < 4) m_cred++;
      for (int i = 0; i < 7; i++) begin
        pv[i] = pv[i+1];
        pd[i] = pd[i+1];
      end
      pv[7] = 1'b0;
      if (fire) begin
        pv[lat-1] = 1'b1;
        pd[lat-1] = next_tag;
        next_tag++;
        n_issued++;
      end
    end
    drive_res();
  endtask

  task automatic wait_occ(input int n, input int budget);
    int c = 0;
    while (q.size() != n && c < budget) begin
      step();
      c++;
    end
    check("wait_occupancy", q.size(), n);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("issue_rdy", issue_rdy, (m_cred != 0) && !rst);
      check("credits", credits, m_cred);
      check("out_vld", out_vld, q.size() != 0);
      if (q.size() != 0) check("out_data", out_data, q[0]);
      check("overflow", overflow, m_ovf);
      if (inv_en && !rst) check("credit_invariant", int'(credits) + inflight() + q.size(), 4);
    end
  end

  initial begin
    int target;
    int c;
    rst = 1'b1; issue_vld = 1'b0; out_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin pv[i] = 1'b0; pd[i] = 8'h00; end
    drive_res();

    // Reset and idle
    step(); step();
    chk_en = 1'b1;
    check("rst_issue_rdy", issue_rdy, 0);
    rst = 1'b0;
    step();
    check("idle_issue_rdy", issue_rdy, 1);
    check("idle_credits", credits, 4);
    check("idle_out_vld", out_vld, 0);
    check("idle_overflow", overflow, 0);

    // Four back-to-back issues, latency 3, downstream stalled
    issue_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("fill_credits", credits, (i < 4) ? 3 - i : 0);
    end
    check("fill_issue_rdy", issue_rdy, 0);
    issue_vld = 1'b0;
    wait_occ(4, 20);
    check("fill_head", out_data, 8'hA1);
    repeat (3) step();
    check("hold_head", out_data, 8'hA1);
    check("hold_vld", out_vld, 1);

    // Pop and issue every cycle
    out_rdy = 1'b1; issue_vld = 1'b1;
    step();
    check("second_entry", out_data, 8'hA2);
    repeat (15) step();
    issue_vld = 1'b0;
    repeat (10) step();
    check("drain_credits", credits, 4);
    check("drain_out_vld", out_vld, 0);

    // Single result into empty FIFO: visible next cycle, no bypass
    inv_en = 1'b0;
    out_rdy = 1'b0;
    frc_v = 1'b1; frc_d = 8'h5A; drive_res();
    check("no_bypass", out_vld, 0);
    step();
    frc_v = 1'b0; drive_res();
    check("lat1_vld", out_vld, 1);
    check("lat1_data", out_data, 8'h5A);
    out_rdy = 1'b1;
    step();
    check("lat1_popped", out_vld, 0);
    out_rdy = 1'b0;

    // Overflow by forcing a result into a full FIFO
    issue_vld = 1'b1;
    repeat (4) step();
    issue_vld = 1'b0;
    wait_occ(4, 20);
    check("pre_overflow", overflow, 0);
    frc_v = 1'b1; frc_d = 8'hEE; drive_res();
    step();
    frc_v = 1'b0; drive_res();
    check("overflow_set", overflow, 1);
    repeat (2) step();
    check("overflow_sticky", overflow, 1);
    out_rdy = 1'b1;
    frc_v = 1'b1; frc_d = 8'hEF; drive_res();
    step();
    frc_v = 1'b0; drive_res();
    check("full_pop_write_refused", credits, 1);
    repeat (3) step();
    check("ovf_drained_vld", out_vld, 0);
    check("ovf_drained_credits", credits, 4);

    // Reset with transfers in flight
    issue_vld = 1'b1;
    repeat (2) step();
    rst = 1'b1; issue_vld = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("midrst_overflow", overflow, 0);
    check("midrst_credits", credits, 4);
    inv_en = 1'b1;

    // Pointer wrap: 11 items with random downstream stalls, latency 2
    lat = 2;
    target = pops + 11;
    n_issued = 0;
    c = 0;
    while (pops != target && c < 300) begin
      issue_vld = (n_issued < 11);
      out_rdy = 1'($urandom_range(0, 1));
      step();
      c++;
    end
    check("wrap_pops", pops, target);
    issue_vld = 1'b0; out_rdy = 1'b0;
    step();
    check("wrap_credits", credits, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
